// File: rtl/walksat_try_scheduler_if.sv
// Handshake bundle between the WalkSAT try scheduler, the host, the re-initialiser and the step controller.
// master = scheduler side, slave = host/partner side.
interface walksat_try_scheduler_if #(
  parameter int MAX_FLIPS = 1024,
  parameter int MAX_TRIES = 16,
  parameter int UNSAT_W   = 16
);
  localparam int FLIP_W = $clog2(MAX_FLIPS + 1);
  localparam int TRY_W  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  logic               start;
  logic               abort_i;
  logic               reinit_o;
  logic               reinit_done_i;
  logic               step_start_o;
  logic               step_done_i;
  logic [UNSAT_W-1:0] unsat_count_i;
  logic               busy_o;
  logic               done;
  logic               sat_o;
  logic               aborted_o;
  logic [FLIP_W-1:0]  flip_cnt_o;
  logic [TRY_W-1:0]   try_cnt_o;
  logic [UNSAT_W-1:0] best_unsat_o;

  modport master (
    input  start, abort_i, reinit_done_i, step_done_i, unsat_count_i,
    output reinit_o, step_start_o, busy_o, done, sat_o, aborted_o,
           flip_cnt_o, try_cnt_o, best_unsat_o
  );

  modport slave (
    output start, abort_i, reinit_done_i, step_done_i, unsat_count_i,
    input  reinit_o, step_start_o, busy_o, done, sat_o, aborted_o,
           flip_cnt_o, try_cnt_o, best_unsat_o
  );
endinterface

// File: rtl/walksat_try_scheduler.sv
// Outer-loop WalkSAT scheduler: restarts, step issue, flip/try budgets, SAT/abort termination.
// Handshake pulses are state-decoded; abort is deferred until no partner handshake is outstanding.
module walksat_try_scheduler #(
  parameter int MAX_FLIPS = 1024,
  parameter int MAX_TRIES = 16,
  parameter int UNSAT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  walksat_try_scheduler_if.master bus
);
  localparam int FLIP_W = $clog2(MAX_FLIPS + 1);
  localparam int TRY_W  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  typedef enum logic [2:0] {
    IDLE, REINIT, WAIT_REINIT, STEP, WAIT_STEP, CHECK, FINISH
  } state_t;

  state_t             state, state_d;
  logic [FLIP_W-1:0]  flip_cnt;
  logic [TRY_W-1:0]   try_cnt;
  logic [UNSAT_W-1:0] best_unsat;
  logic [UNSAT_W-1:0] unsat_q;
  logic               sat_q;
  logic               aborted_q;
  logic               abort_pending;
  logic               flip_more;
  logic               try_more;
  logic               is_sat;

  assign flip_more = (int'(flip_cnt) + 1) < MAX_FLIPS;
  assign try_more  = (int'(try_cnt) + 1) < MAX_TRIES;
  assign is_sat    = (unsat_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:        if (bus.start) state_d = REINIT;
      REINIT:      state_d = WAIT_REINIT;
      WAIT_REINIT: if (bus.reinit_done_i) state_d = abort_pending ? FINISH : STEP;
      STEP:        state_d = WAIT_STEP;
      WAIT_STEP:   if (bus.step_done_i) state_d = CHECK;
      CHECK: begin
        if (is_sat || abort_pending) state_d = FINISH;
        else if (flip_more)          state_d = STEP;
        else if (try_more)           state_d = REINIT;
        else                         state_d = FINISH;
      end
      FINISH:      state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flip_cnt      <= '0;
      try_cnt       <= '0;
      best_unsat    <= '0;
      unsat_q       <= '0;
      sat_q         <= 1'b0;
      aborted_q     <= 1'b0;
      abort_pending <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (bus.start) begin
          flip_cnt      <= '0;
          try_cnt       <= '0;
          best_unsat    <= '1;
          sat_q         <= 1'b0;
          aborted_q     <= 1'b0;
          abort_pending <= 1'b0;
        end
      end else if (bus.abort_i) begin
        abort_pending <= 1'b1;
      end

      if (state == WAIT_STEP && bus.step_done_i) begin
        unsat_q <= bus.unsat_count_i;
        if (bus.unsat_count_i < best_unsat) best_unsat <= bus.unsat_count_i;
      end

      // SAT outranks abort; budget exhaustion parks flip_cnt at MAX_FLIPS.
      if (state == CHECK) begin
        if (is_sat) begin
          sat_q <= 1'b1;
        end else if (abort_pending) begin
          aborted_q <= 1'b1;
        end else if (flip_more) begin
          flip_cnt <= flip_cnt + FLIP_W'(1);
        end else if (try_more) begin
          try_cnt  <= try_cnt + TRY_W'(1);
          flip_cnt <= '0;
        end else begin
          flip_cnt <= FLIP_W'(MAX_FLIPS);
        end
      end
    end
  end

  assign bus.reinit_o     = (state == REINIT);
  assign bus.step_start_o = (state == STEP);
  assign bus.busy_o       = (state != IDLE);
  assign bus.done         = (state == FINISH);
  assign bus.sat_o        = sat_q;
  assign bus.aborted_o    = aborted_q;
  assign bus.flip_cnt_o   = flip_cnt;
  assign bus.try_cnt_o    = try_cnt;
  assign bus.best_unsat_o = best_unsat;
endmodule
